bus_store_arbiter: RTL and testbench
====================================

// Module: bus_store_arbiter
// PURPOSE
//  Arbitrates the shared AXI write (store) bus between master0 and master1.
//  Drives m0_grnt/m1_grnt into the store-bus master mux, sampling the mux's shared-side handshakes.
//  Holds a grant for one complete write transaction: AW, all W beats through wlast, then the B response.
//  Round-robin or fixed priority; a watchdog flags transactions that hang.
// PARAMETERS
//  RR_EN        1     1: round-robin between m0/m1; 0: fixed priority, m0 always wins
//  WDOG_CYCLES  1024  cycles a grant may be held before wdog_err sets; 0 disables watchdog
//  WDOG_W       11    width of watchdog counter; must satisfy WDOG_CYCLES < 2**WDOG_W
// PORTS
//  clk       in   1  clock, all state updates on rising edge
//  rst       in   1  reset, asynchronous, active-high
//  m0_req    in   1  master0 requests the store bus (held until granted)
//  m1_req    in   1  master1 requests the store bus (held until granted)
//  awvalid   in   1  shared-bus AW valid (mux output side)
//  awready   in   1  shared-bus AW ready
//  wvalid    in   1  shared-bus W valid
//  wready    in   1  shared-bus W ready
//  wlast     in   1  shared-bus W last beat
//  bvalid    in   1  shared-bus B valid
//  bready    in   1  shared-bus B ready
//  m0_grnt   out  1  grant to master0 (registered)
//  m1_grnt   out  1  grant to master1 (registered)
//  busy      out  1  a grant is active
//  wdog_err  out  1  sticky: a grant exceeded WDOG_CYCLES
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, m0_grnt=m1_grnt=busy=wdog_err=0, aw_done=w_done=0, wdog cnt=0, last_grnt=1 (m0 wins first tie).
//  m0_grnt and m1_grnt are never both 1.
//  States: IDLE, GNT0, GNT1. busy=1 in GNT0/GNT1.
//  IDLE: sample m0_req/m1_req at the clock edge; grant is visible the next cycle (1-cycle latency).
//   - Only one request: grant it.
//   - Both, RR_EN=1: grant the master not equal to last_grnt.
//   - Both, RR_EN=0: grant m0.
//   - None: stay IDLE.
//   - On any grant, load last_grnt and clear aw_done, w_done, wdog cnt.
//  GNTx: aw_done sets on awvalid&awready. w_done sets on wvalid&wready&wlast.
//   - AW and last W may complete in either order or in the same cycle; track them independently.
//   - Release on bvalid&bready with aw_done&w_done (flags including same-cycle set): next state IDLE, grants 0.
//   - A B handshake before both flags are set is ignored; stay in GNTx.
//   - After release there is at least one IDLE cycle before the next grant; no back-to-back grant.
//  Watchdog: cnt increments each GNTx cycle, saturating at WDOG_CYCLES.
//   - wdog_err sets when cnt==WDOG_CYCLES-1 and no release that cycle.
//   - The grant is NOT revoked, to protect the AXI protocol.
//   - wdog_err clears only on rst.
//  Requests dropping during GNTx are ignored; the grant is released only by B completion or rst.
//  rst mid-transaction: grants drop asynchronously; the slave side is reset by the same rst.
// TESTING
//  - Single m0 write, awlen=0, AW+W same cycle, B 3 cycles later -> m0_grnt high 1 cycle after req; low the cycle after the B handshake.
//  - m0_req&m1_req both set from reset, RR_EN=1, two 1-beat writes each -> grant order m0,m1,m0,m1 with one IDLE cycle between.
//  - RR_EN=0, both requests held, 3 transactions -> m0 granted all 3; m1 never granted.
//  - 4-beat burst with W wlast before AW handshake, B after AW -> aw_done/w_done set out of order; release only after bvalid&bready.
//  - WDOG_CYCLES=8, bvalid never asserted -> wdog_err=1 on the 9th granted cycle, stays 1 while m1_grnt never asserts; rst clears all.
//  - rst asserted mid-burst (beat 2 of 4) -> m0_grnt/busy drop at once (no clock edge); after rst release, IDLE with last_grnt=1.

Source files
------------

// File: rtl/bus_store_arbiter_if.sv
// Store-bus arbitration interface: request/grant lines plus the shared-side
// AXI write handshakes that the arbiter observes.
interface bus_store_arbiter_if;
  logic m0_req;
  logic m1_req;
  logic awvalid;
  logic awready;
  logic wvalid;
  logic wready;
  logic wlast;
  logic bvalid;
  logic bready;
  logic m0_grnt;
  logic m1_grnt;
  logic busy;
  logic wdog_err;

  modport master (
    input  m0_req, m1_req,
    input  awvalid, awready, wvalid, wready, wlast, bvalid, bready,
    output m0_grnt, m1_grnt, busy, wdog_err
  );

  modport slave (
    output m0_req, m1_req,
    output awvalid, awready, wvalid, wready, wlast, bvalid, bready,
    input  m0_grnt, m1_grnt, busy, wdog_err
  );
endinterface

// File: rtl/bus_store_arbiter.sv
// Two-master arbiter for the shared AXI store bus. A grant covers one whole
// write (AW, W through wlast, B) and a sticky watchdog flags hung grants.
module bus_store_arbiter #(
  parameter bit          RR_EN       = 1'b1,
  parameter int unsigned WDOG_CYCLES = 1024,
  parameter int unsigned WDOG_W      = 11
) (
  input  logic               clk,
  input  logic               rst,
  bus_store_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam bit              WDOG_EN   = (WDOG_CYCLES != 0);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_TRIP = WDOG_W'(WDOG_CYCLES - 1);

  state_t              state_r, state_s;
  logic                aw_done_r, aw_done_s;
  logic                w_done_r, w_done_s;
  logic                last_grnt_r, last_grnt_s;
  logic [WDOG_W-1:0]   wdog_cnt_r, wdog_cnt_s;
  logic                wdog_err_r, wdog_err_s;
  logic                m0_grnt_r, m1_grnt_r, busy_r;
  logic                aw_hs_s, wl_hs_s, b_hs_s;
  logic                release_s, pick_m1_s;

  assign aw_hs_s = bus.awvalid & bus.awready;
  assign wl_hs_s = bus.wvalid & bus.wready & bus.wlast;
  assign b_hs_s  = bus.bvalid & bus.bready;

  // Next-state, completion flags and watchdog
  always_comb begin
    state_s     = state_r;
    aw_done_s   = aw_done_r;
    w_done_s    = w_done_r;
    last_grnt_s = last_grnt_r;
    wdog_cnt_s  = wdog_cnt_r;
    wdog_err_s  = wdog_err_r;
    release_s   = 1'b0;
    pick_m1_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // last_grnt: 0 = m0 last, 1 = m1 last; a tie goes to the other one
        if (bus.m0_req && bus.m1_req) begin
          if (RR_EN) begin
            pick_m1_s = ~last_grnt_r;
          end else begin
            pick_m1_s = 1'b0;
          end
        end else begin
          pick_m1_s = bus.m1_req;
        end
        if (bus.m0_req || bus.m1_req) begin
          state_s     = pick_m1_s ? GNT1 : GNT0;
          last_grnt_s = pick_m1_s;
          aw_done_s   = 1'b0;
          w_done_s    = 1'b0;
          wdog_cnt_s  = {WDOG_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      GNT0, GNT1: begin
        aw_done_s = aw_done_r | aw_hs_s;
        w_done_s  = w_done_r | wl_hs_s;
        release_s = b_hs_s & aw_done_s & w_done_s;
        if (release_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
        if (WDOG_EN) begin
          if (wdog_cnt_r != WDOG_MAX) begin
            wdog_cnt_s = wdog_cnt_r + WDOG_W'(1);
          end else begin
            wdog_cnt_s = wdog_cnt_r;
          end
          // The grant is never revoked here: cutting a live AXI burst is worse
          if ((wdog_cnt_r == WDOG_TRIP) && !release_s) begin
            wdog_err_s = 1'b1;
          end else begin
            wdog_err_s = wdog_err_r;
          end
        end else begin
          wdog_cnt_s = wdog_cnt_r;
          wdog_err_s = wdog_err_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, flags and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      last_grnt_r <= 1'b1;
      wdog_cnt_r  <= {WDOG_W{1'b0}};
      wdog_err_r  <= 1'b0;
      m0_grnt_r   <= 1'b0;
      m1_grnt_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      aw_done_r   <= aw_done_s;
      w_done_r    <= w_done_s;
      last_grnt_r <= last_grnt_s;
      wdog_cnt_r  <= wdog_cnt_s;
      wdog_err_r  <= wdog_err_s;
      m0_grnt_r   <= (state_s == GNT0);
      m1_grnt_r   <= (state_s == GNT1);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign bus.m0_grnt  = m0_grnt_r;
  assign bus.m1_grnt  = m1_grnt_r;
  assign bus.busy     = busy_r;
  assign bus.wdog_err = wdog_err_r;

endmodule

// File: tb/tb_bus_store_arbiter.sv
// Bench: three arbiters (round-robin, fixed priority, short watchdog) share one
// stimulus; a per-instance queue holds the master each next grant must go to.
module tb_bus_store_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic m0_req, m1_req, awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [2:0] g0_v, g1_v, busy_v, err_v;

  int checks = 0;
  int errors = 0;
  logic q0[$];
  logic q1[$];
  logic q2[$];

  // instance 0: RR, long watchdog; 1: fixed priority; 2: RR, WDOG_CYCLES=8
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam bit          RR = (g == 1) ? 1'b0 : 1'b1;
    localparam int unsigned WD = (g == 2) ? 8 : 1024;
    localparam int unsigned WW = (g == 2) ? 4 : 11;
    bus_store_arbiter_if bif ();
    assign bif.m0_req  = m0_req;
    assign bif.m1_req  = m1_req;
    assign bif.awvalid = awvalid;
    assign bif.awready = awready;
    assign bif.wvalid  = wvalid;
    assign bif.wready  = wready;
    assign bif.wlast   = wlast;
    assign bif.bvalid  = bvalid;
    assign bif.bready  = bready;
    assign g0_v[g]   = bif.m0_grnt;
    assign g1_v[g]   = bif.m1_grnt;
    assign busy_v[g] = bif.busy;
    assign err_v[g]  = bif.wdog_err;
    bus_store_arbiter #(.RR_EN(RR), .WDOG_CYCLES(WD), .WDOG_W(WW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_bus();
    awvalid = 1'b0; awready = 1'b0; wvalid = 1'b0; wready = 1'b0;
    wlast = 1'b0; bvalid = 1'b0; bready = 1'b0;
  endtask

  task automatic push_all(input logic e0, input logic e1, input logic e2);
    q0.push_back(e0);
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  // Pop the expected owner of the grant just raised and compare {m1,m0}
  task automatic check_grant();
    logic e;
    chk("sb0_pending", 32'(q0.size() != 0), 32'd1);
    if (q0.size() != 0) begin
      e = q0.pop_front();
      chk("rr_owner", {30'd0, g1_v[0], g0_v[0]}, e ? 32'd2 : 32'd1);
    end
    chk("sb1_pending", 32'(q1.size() != 0), 32'd1);
    if (q1.size() != 0) begin
      e = q1.pop_front();
      chk("fp_owner", {30'd0, g1_v[1], g0_v[1]}, e ? 32'd2 : 32'd1);
    end
    chk("sb2_pending", 32'(q2.size() != 0), 32'd1);
    if (q2.size() != 0) begin
      e = q2.pop_front();
      chk("wd_owner", {30'd0, g1_v[2], g0_v[2]}, e ? 32'd2 : 32'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    clear_bus();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    clear_bus();
    tick();
    tick();
    chk("reset_state", {20'd0, g0_v, g1_v, busy_v, err_v}, 32'd0);
    rst = 1'b0;
    tick();

    // Single m0 write, AW+W together, B three cycles later
    m0_req = 1'b1;
    push_all(1'b0, 1'b0, 1'b0);
    tick();
    chk("t1_latency", 32'(g0_v), 32'd7);
    check_grant();
    m0_req = 1'b0;
    awvalid = 1'b1; awready = 1'b1; wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
    tick();
    clear_bus();
    tick();
    tick();
    chk("t1_hold_before_b", 32'(busy_v), 32'd7);
    bvalid = 1'b1; bready = 1'b1;
    tick();
    clear_bus();
    chk("t1_release", {26'd0, g0_v, busy_v}, 32'd0);

    // Both requests held: RR alternates, fixed priority always m0
    do_reset();
    m0_req = 1'b1;
    m1_req = 1'b1;
    push_all(1'b0, 1'b0, 1'b0);
    push_all(1'b1, 1'b0, 1'b1);
    push_all(1'b0, 1'b0, 1'b0);
    push_all(1'b1, 1'b0, 1'b1);
    tick();
    for (int n = 0; n < 4; n++) begin
      check_grant();
      awvalid = 1'b1; awready = 1'b1; wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
      tick();
      clear_bus();
      bvalid = 1'b1; bready = 1'b1;
      tick();
      clear_bus();
      chk("t2_idle_gap", {29'd0, busy_v}, 32'd0);
      if (n < 3) begin
        tick();
      end else begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    chk("t2_no_wdog", 32'(err_v), 32'd0);

    // 4-beat burst, wlast before AW; early B ignored; AW and B same cycle
    do_reset();
    m0_req = 1'b1;
    push_all(1'b0, 1'b0, 1'b0);
    tick();
    check_grant();
    m0_req = 1'b0;
    awvalid = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      wvalid = 1'b1; wready = 1'b1; wlast = (b == 4);
      tick();
    end
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    bvalid = 1'b1; bready = 1'b1;
    tick();
    chk("t3_early_b_ignored", 32'(g0_v), 32'd7);
    awready = 1'b1;
    tick();
    clear_bus();
    chk("t3_release", {29'd0, busy_v}, 32'd0);
    chk("t3_no_wdog", 32'(err_v), 32'd0);

    // Watchdog: B never arrives; m1 keeps requesting
    do_reset();
    m0_req = 1'b1;
    m1_req = 1'b1;
    push_all(1'b0, 1'b0, 1'b0);
    tick();
    check_grant();
    awvalid = 1'b1; awready = 1'b1; wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
    tick();
    clear_bus();
    for (int k = 2; k <= 12; k++) begin
      chk($sformatf("t4_wdog_c%0d", k), 32'(err_v), (k >= 9) ? 32'd4 : 32'd0);
      chk($sformatf("t4_hold_c%0d", k), {26'd0, g0_v, g1_v}, 32'h38);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("t4_rst_clears", {23'd0, g0_v, g1_v, busy_v}, 32'd0);
    chk("t4_rst_err", 32'(err_v), 32'd0);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Reset mid-burst during beat 2: grants drop without a clock edge
    m0_req = 1'b1;
    push_all(1'b0, 1'b0, 1'b0);
    tick();
    check_grant();
    m0_req = 1'b0;
    awvalid = 1'b1; awready = 1'b1; wvalid = 1'b1; wready = 1'b1;
    tick();
    awvalid = 1'b0; awready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("t5_async_drop", {26'd0, g0_v, busy_v}, 32'd0);
    clear_bus();
    tick();
    rst = 1'b0;
    tick();
    chk("t5_idle_after_rst", {29'd0, busy_v}, 32'd0);
    m0_req = 1'b1;
    m1_req = 1'b1;
    push_all(1'b0, 1'b0, 1'b0);
    tick();
    check_grant();
    m0_req = 1'b0;
    m1_req = 1'b0;
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
